// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and FIPS 180-4 bit-mixing functions
// used by the single-block 96-bit message hashing core.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_e;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Fixed 96-bit message: 0x80 marker, zero fill, then the 64-bit bit length.
    function automatic logic [511:0] pad_block(input logic [95:0] msg);
        return {msg, 8'h80, 344'd0, 64'd96};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: maps a..h plus K[t], W[t]
// onto the next set of working variables.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    input  logic [31:0] e_in,
    input  logic [31:0] f_in,
    input  logic [31:0] g_in,
    input  logic [31:0] h_in,
    input  logic [31:0] k_in,
    input  logic [31:0] w_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out,
    output logic [31:0] e_out,
    output logic [31:0] f_out,
    output logic [31:0] g_out,
    output logic [31:0] h_out
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1    = h_in + big_sigma1(e_in) + ch(e_in, f_in, g_in) + k_in + w_in;
        t2    = big_sigma0(a_in) + maj(a_in, b_in, c_in);
        a_out = t1 + t2;
        b_out = a_in;
        c_out = b_in;
        d_out = c_in;
        e_out = d_in + t1;
        f_out = e_in;
        g_out = f_in;
        h_out = g_in;
    end

endmodule

// File: rtl/sha256_top.sv
// Single-block SHA-256 core for a fixed 12-byte message: LOAD, 64 rounds at one
// per clock, FINAL digest add, then DONE holds the digest until reset.
module sha256_top
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [95:0]  message,
    output logic         trigger,
    output logic [255:0] H_out
);

    state_e         state_q, state_d;
    logic [5:0]     t_q, t_d;
    logic [31:0]    w_q [0:15];
    logic [31:0]    w_d [0:15];
    logic [31:0]    work_q [0:7];
    logic [31:0]    work_d [0:7];
    logic [31:0]    rnd [0:7];
    logic [255:0]   h_out_q, h_out_d;
    logic           trigger_q, trigger_d;
    logic [511:0]   block;
    logic [31:0]    w_next;

    sha256_round u_round (
        .a_in  (work_q[0]),
        .b_in  (work_q[1]),
        .c_in  (work_q[2]),
        .d_in  (work_q[3]),
        .e_in  (work_q[4]),
        .f_in  (work_q[5]),
        .g_in  (work_q[6]),
        .h_in  (work_q[7]),
        .k_in  (K[t_q]),
        .w_in  (w_q[0]),
        .a_out (rnd[0]),
        .b_out (rnd[1]),
        .c_out (rnd[2]),
        .d_out (rnd[3]),
        .e_out (rnd[4]),
        .f_out (rnd[5]),
        .g_out (rnd[6]),
        .h_out (rnd[7])
    );

    always_comb begin
        block     = pad_block(message);
        // Window holds W[t..t+15]; this produces W[t+16].
        w_next    = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        state_d   = state_q;
        t_d       = t_q;
        w_d       = w_q;
        work_d    = work_q;
        h_out_d   = h_out_q;
        trigger_d = trigger_q;

        case (state_q)
            ST_LOAD: begin
                work_d = IV;
                for (int unsigned i = 0; i < 16; i++) begin
                    w_d[i] = block[511 - 32*i -: 32];
                end
                t_d     = '0;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                work_d = rnd;
                for (int unsigned i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i + 1];
                end
                w_d[15] = w_next;
                if (t_q == 6'd63) begin
                    state_d = ST_FINAL;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            ST_FINAL: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    h_out_d[255 - 32*i -: 32] = IV[i] + work_q[i];
                end
                trigger_d = 1'b1;
                state_d   = ST_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_LOAD;
            t_q       <= '0;
            w_q       <= '{default: '0};
            work_q    <= '{default: '0};
            h_out_q   <= '0;
            trigger_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            w_q       <= w_d;
            work_q    <= work_d;
            h_out_q   <= h_out_d;
            trigger_q <= trigger_d;
        end
    end

    assign trigger = trigger_q;
    assign H_out   = h_out_q;

endmodule

// File: tb/tb_sha256_top.sv
// Directed bench for sha256_top: digests come from an independent full-schedule
// SHA-256 reference, itself anchored to the well-known SHA-256("abc") value.
module tb_sha256_top;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [95:0]  message = '0;
    logic         trigger;
    logic [255:0] H_out;

    int compared   = 0;
    int mismatched = 0;

    sha256_top dut (
        .clk     (clk),
        .reset   (reset),
        .message (message),
        .trigger (trigger),
        .H_out   (H_out)
    );

    always #10 clk = ~clk;

    localparam logic [31:0] TK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] TIV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_hash(input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] v [0:7];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = m_rotr(w[i-15], 7) ^ m_rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = m_rotr(w[i-2], 17) ^ m_rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = TIV[i];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (m_rotr(v[4], 6) ^ m_rotr(v[4], 11) ^ m_rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[i] + w[i];
            t2 = (m_rotr(v[0], 2) ^ m_rotr(v[0], 13) ^ m_rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = TIV[i] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] hash96(input logic [95:0] m);
        return ref_hash({m, 8'h80, 344'd0, 64'd96});
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds reset two cycles, releases it mid-cycle, checks trigger timing and digest.
    task automatic run_hash(input string tag, input logic [95:0] m);
        logic [255:0] exp_d;
        exp_d   = hash96(m);
        reset   = 1'b0;
        message = m;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int e = 1; e <= 66; e++) begin
            @(posedge clk); #1;
            if (e == 65) check({tag, "_trig_e65"}, 256'(trigger), 256'(0));
            if (e == 66) begin
                check({tag, "_trig_e66"}, 256'(trigger), 256'(1));
                check({tag, "_digest"}, H_out, exp_d);
            end
        end
    endtask

    initial begin
        logic [95:0]  msg_love;
        logic [95:0]  msg_hello;
        logic [95:0]  msg_sv;
        logic [255:0] snap;
        int           bad;
        int           edges;
        msg_love  = "weloveaustin";
        msg_hello = "hello world!";
        msg_sv    = "SystemVerilo";

        check("model_abc", ref_hash({24'h616263, 8'h80, 416'd0, 64'd24}),
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // Reset held low for 100 cycles.
        reset   = 1'b0;
        message = msg_love;
        bad     = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (H_out !== '0 || trigger !== 1'b0) bad++;
        end
        check("rst_hold_glitches", 256'(bad), 256'(0));
        check("rst_hold_hout", H_out, '0);
        check("rst_hold_trig", 256'(trigger), 256'(0));

        run_hash("love", msg_love);

        // Asynchronous clear after completion, before any further edge.
        @(posedge clk); #5 reset = 1'b0;
        #1;
        check("async_clr_hout", H_out, '0);
        check("async_clr_trig", 256'(trigger), 256'(0));

        run_hash("zero", '0);

        // Abort at edge 30, then hash a new message.
        reset   = 1'b0;
        message = msg_love;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (30) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_trig", 256'(trigger), 256'(0));
        check("abort_hout", H_out, '0);
        repeat (2) @(posedge clk);
        message = msg_hello;
        @(negedge clk) reset = 1'b1;
        edges = 0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (trigger === 1'b1) begin
                edges = e;
                break;
            end
        end
        check("hello_trig_edge", 256'(edges), 256'(66));
        check("hello_digest", H_out, hash96(msg_hello));

        // DONE must hold steady without re-hashing.
        snap = hash96(msg_hello);
        bad  = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (H_out !== snap || trigger !== 1'b1) bad++;
        end
        check("done_hold_changes", 256'(bad), 256'(0));
        check("done_hold_digest", H_out, snap);

        // Message changes after LOAD are ignored.
        reset   = 1'b0;
        message = msg_sv;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int e = 1; e <= 66; e++) begin
            @(posedge clk); #1;
            if (e == 10) message = '1;
            if (e == 65) check("chg_trig_e65", 256'(trigger), 256'(0));
        end
        check("chg_trig_e66", 256'(trigger), 256'(1));
        check("chg_digest", H_out, hash96(msg_sv));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
